// File: rtl/ncl_handshake_sink.sv
// Four-phase handshake sink for an NCL token pipeline: synchronizes req_in,
// hands each word downstream once, and checks it against an x*(x+1) model.
module ncl_handshake_sink #(
    parameter int DW   = 15,
    parameter int FW   = 26,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_in,
    input  logic [DW-1:0] data_in,
    output logic          ack_out,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic          check_en,
    output logic [15:0]   tok_count,
    output logic [7:0]    err_count,
    output logic          err_sticky
);

    typedef enum logic [1:0] {IDLE, HOLD, ACK, DROP} state_t;

    state_t          state_q, state_d;
    logic [SYNC-1:0] sync_q, sync_d;
    logic            ack_q, ack_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [15:0]     tok_q, tok_d;
    logic [7:0]      err_q, err_d;
    logic            sticky_q, sticky_d;
    logic [FW-1:0]   exp_q, exp_d;
    logic [FW-1:0]   stp_q, stp_d;
    logic            req_s;
    logic            accept;
    logic [DW-1:0]   exp_fold;

    assign req_s    = sync_q[SYNC-1];
    assign sync_d   = {sync_q[SYNC-2:0], req_in};
    assign exp_fold = DW'(exp_q >> DW) ^ exp_q[DW-1:0];

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        valid_d  = valid_q;
        data_d   = data_q;
        tok_d    = tok_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        stp_d    = stp_q;
        accept   = 1'b0;

        unique case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = DROP;
                end
            end
            DROP: begin
                // guarantees one low-ack cycle before the next capture
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            if (tok_q != 16'hFFFF) begin
                tok_d = tok_q + 16'd1;
            end
            exp_d = exp_q + stp_q;
            stp_d = stp_q + FW'(2);
            if (check_en && (data_q != exp_fold)) begin
                sticky_d = 1'b1;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            tok_q    <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            stp_q    <= FW'(2);
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            tok_q    <= tok_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            stp_q    <= stp_d;
        end
    end

    assign ack_out    = ack_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign tok_count  = tok_q;
    assign err_count  = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_ncl_handshake_sink.sv
// Directed/randomized bench for ncl_handshake_sink with a 4-phase upstream
// source and an arithmetic x*(x+1) reference.
module tb_ncl_handshake_sink;

    logic        clk;
    logic        rst_n;
    logic        req_in;
    logic [14:0] data_in;
    logic        ack_out;
    logic        out_valid;
    logic [14:0] out_data;
    logic        out_ready;
    logic        check_en;
    logic [15:0] tok_count;
    logic [7:0]  err_count;
    logic        err_sticky;

    int nvec = 0;
    int nerr = 0;

    ncl_handshake_sink #(.DW(15), .FW(26), .SYNC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .check_en  (check_en),
        .tok_count (tok_count),
        .err_count (err_count),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] xw(input longint x);
        longint v;
        v = (x * (x + 1)) & 64'h3FF_FFFF;
        return 15'(((v >> 15) ^ v) & 64'h7FFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_in    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // one full 4-phase cycle; hold>0 applies downstream backpressure
    task automatic send(input logic [14:0] d, input int hold);
        int n;
        logic [14:0] cap;
        data_in = d;
        req_in  = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("valid_latency", n, 3);
        chk("valid_rise", out_valid, 1);
        chk("capture", out_data, d);
        cap = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_ack_low", ack_out, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data_hold", out_data, cap);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("ack_rise", ack_out, 1);
        chk("valid_clear", out_valid, 0);
        req_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_out && n < 20);
        chk("ack_fall", ack_out, 0);
        chk("data_after", out_data, cap);
    endtask

    initial begin
        logic [15:0] t0;
        int n;
        rst_n     = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        check_en  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tok", tok_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_sticky", err_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // idle with noise on data_in must not capture
        repeat (5) begin
            data_in = 15'($urandom);
            @(negedge clk);
            chk("idle_novalid", out_valid, 0);
        end

        for (int x = 0; x < 20; x++) send(xw(x), 0);
        chk("loop_tok", tok_count, 20);
        chk("loop_err", err_count, 0);
        chk("loop_sticky", err_sticky, 0);

        t0 = tok_count;
        send(xw(20), 10);
        chk("bp_tok", tok_count, t0 + 16'd1);
        chk("bp_err", err_count, 0);

        // random backpressure lengths
        for (int x = 21; x < 30; x++) send(xw(x), int'($urandom_range(0, 6)));
        chk("rbp_tok", tok_count, 30);
        chk("rbp_err", err_count, 0);

        do_reset();
        for (int x = 0; x < 5; x++) send(xw(x), 0);
        chk("corrupt_val", xw(5) ^ 15'd8, 22);
        send(xw(5) ^ 15'd8, 0);
        chk("corrupt_err", err_count, 1);
        chk("corrupt_sticky", err_sticky, 1);
        send(xw(6), 0);
        chk("tok6_err", err_count, 1);
        chk("tok6_tok", tok_count, 7);

        do_reset();
        for (int x = 0; x < 5; x++) send(xw(x), 0);
        check_en = 1'b0;
        send(xw(5) ^ 15'd8, 0);
        check_en = 1'b1;
        for (int x = 6; x < 10; x++) send(xw(x), 0);
        chk("chkoff_err", err_count, 0);
        chk("chkoff_sticky", err_sticky, 0);
        chk("chkoff_tok", tok_count, 10);

        do_reset();
        for (int x = 0; x < 3; x++) send(xw(x), 0);
        data_in = xw(3);
        req_in  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_out && n < 20);
        chk("pre_rst_ack", ack_out, 1);
        rst_n  = 1'b0;
        req_in = 1'b0;
        @(negedge clk);
        chk("racq_ack", ack_out, 0);
        chk("racq_valid", out_valid, 0);
        chk("racq_tok", tok_count, 0);
        chk("racq_data", out_data, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("racq_idle", out_valid, 0);
        for (int x = 0; x < 5; x++) send(xw(x), 0);
        chk("racq_err", err_count, 0);
        chk("racq_tok5", tok_count, 5);

        do_reset();
        for (int x = 0; x < 260; x++) send(xw(x) ^ 15'd1, 0);
        chk("esat_err", err_count, 8'hFF);
        chk("esat_sticky", err_sticky, 1);
        chk("esat_tok", tok_count, 260);

        do_reset();
        for (int x = 0; x < 8200; x++) send(xw(x), 0);
        chk("wrap_err", err_count, 0);
        chk("wrap_sticky", err_sticky, 0);
        chk("wrap_tok", tok_count, 8200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ncl_handshake_sink.md
NCL_HANDSHAKE_SINK -- requirements
Module: ncl_handshake_sink

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 15: width of the folded data word.
- FW, 26: width of the upstream pipeline word before folding.
- SYNC, 2: number of synchronizer flops on req_in; minimum 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: the single clock.
- rst_n, in, 1: reset; synchronous and active-low.
- req_in, in, 1: 4-phase request from the upstream token pipeline; asynchronous to clk.
- data_in, in, DW: folded upstream word; stable while req_in=1 and until ack_out rises.
- ack_out, out, 1: 4-phase acknowledge to upstream; registered.
- out_valid, out, 1: captured word available downstream.
- out_data, out, DW: captured word.
- out_ready, in, 1: downstream accepts the word when out_valid=1.
- check_en, in, 1: enables the sequence checker.
- tok_count, out, 16: tokens accepted; saturating.
- err_count, out, 8: checker mismatches; saturating.
- err_sticky, out, 1: set on the first mismatch; cleared only by reset.

Function
REQ-003 req_in shall pass through SYNC flops; req_s is the last stage. The FSM shall act on req_s only.
REQ-004 FSM states shall be IDLE, HOLD, ACK and DROP.
REQ-005 IDLE: ack_out=0. On req_s=1, latch data_in into out_data and go to HOLD.
REQ-006 HOLD: out_valid=1. On out_ready=1, clear out_valid, set ack_out=1 and go to ACK.
REQ-007 ACK: ack_out=1. On req_s=0, set ack_out=0 and go to DROP.
REQ-008 DROP: ack_out=0 for exactly one cycle, then go to IDLE. This guarantees ack_out low lasts at least one cycle before the next capture.
REQ-009 out_data shall not change outside the IDLE-to-HOLD capture edge.
REQ-010 A return-to-zero cycle of req_in shorter than SYNC cycles may go unseen. Required behaviour: no spurious capture and no deadlock. Upstream cannot reissue req_in before ack_out, so this cannot occur in legal operation.
REQ-011 Accepted-token definition: the HOLD-to-ACK transition (out_valid=1 and out_ready=1).
REQ-012 tok_count shall increment by 1 per accepted token and hold at 0xFFFF.
REQ-013 Checker model: a FW-bit register exp_full, initialised to 0, and a FW-bit step register stp, initialised to 2.
REQ-014 On each accepted token: exp_full += stp; stp += 2. Both wrap modulo 2^FW. This reproduces x*(x+1) for x=0,1,2,...
REQ-015 Expected folded word: exp15 = (exp_full >> DW) XOR exp_full[DW-1:0], truncated to DW bits.
REQ-016 On an accepted token with check_en=1 and out_data != exp15:
- err_count shall increment and hold at 0xFF.
- err_sticky shall be set.
REQ-017 The checker model shall advance on every accepted token regardless of check_en.
REQ-018 An accepted token and downstream backpressure shall never drop or duplicate a word: exactly one out_valid/out_ready transfer per 4-phase cycle.
REQ-019 Latency from req_in rising to out_valid shall be SYNC+1 cycles. out_valid rises at clock edge SYNC+1 after the req_in edge is sampled.
REQ-020 Latency from out_ready=1 in HOLD to ack_out=1 shall be 1 cycle.

Reset
REQ-021 When rst_n=0 at a clk edge, all of the following shall take their reset values on that edge:
- FSM to IDLE.
- ack_out=0, out_valid=0, out_data=0.
- Synchronizer flops to 0.
- tok_count=0, err_count=0, err_sticky=0.
- exp_full=0, stp=2.
REQ-022 Reset mid-handshake (HOLD or ACK) shall drop ack_out on the reset edge with no pending token retained. After release, the block shall wait in IDLE for req_s=1; upstream is expected to be reset by the same rst_n.
REQ-023 No output shall depend combinationally on req_in or data_in.

Verification
REQ-024 Loop-back stream: model upstream as a 4-phase x*(x+1) source, out_ready=1, check_en=1, run 20 tokens -> out_data sequence 0, 2, 6, 12, 20, ...; tok_count=20; err_count=0; err_sticky=0.
REQ-025 Backpressure: out_ready=0 for 10 cycles after out_valid rises -> ack_out stays 0 and out_data holds. After out_ready=1 -> ack_out=1 in the next cycle; tok_count increments by exactly 1.
REQ-026 Corruption: flip bit 3 of token 5 (expected 30, drive 22) with check_en=1 -> err_count=1 and err_sticky=1. Token 6 (42) is still checked correct.
REQ-027 check_en=0 during corrupted token 5, then check_en=1 -> err_count=0, and later tokens check correctly, proving the model still advanced.
REQ-028 Reset in ACK: assert rst_n=0 for 1 cycle while ack_out=1 -> ack_out=0, out_valid=0 and tok_count=0 on that edge. A fresh stream from 0 then passes with err_count=0.
REQ-029 Wrap: preload by running tokens until exp_full crosses 2^26 (x=8192) -> exp15 matches the folded modulo-2^26 value; tok_count saturation at 0xFFFF is checked with a forced-count test.
